// File: rtl/neuron_vec_loader.sv
// Feeds the packed-input neuron: gathers one frame of (weight, input) pairs,
// strobes the neuron enable for its pipeline depth, and returns the captured output.
module neuron_vec_loader #(
    parameter int unsigned N            = 64,
    parameter int unsigned N_INPUTS     = 16,
    parameter int unsigned LOG_N_INPUTS = 4,
    parameter int unsigned LATENCY      = 2
) (
    input  logic                    clk,
    input  logic                    rst_n,
    input  logic                    clear,
    input  logic                    in_valid,
    output logic                    in_ready,
    input  logic [N-1:0]            in_w,
    input  logic [N-1:0]            in_x,
    output logic [N*N_INPUTS-1:0]   w_packed,
    output logic [N*N_INPUTS-1:0]   x_packed,
    output logic                    neu_en,
    input  logic [N-1:0]            neu_out,
    output logic                    res_valid,
    input  logic                    res_ready,
    output logic [N-1:0]            res_data,
    output logic                    busy
);

    localparam int unsigned EW = (LATENCY > 1) ? $clog2(LATENCY) : 1;

    typedef enum logic [1:0] {LOAD, FIRE, CAPT, DONE} state_t;

    state_t                  state, state_d;
    logic [LOG_N_INPUTS-1:0] slot, slot_d;
    logic [EW-1:0]           en_cnt, en_cnt_d;
    logic                    accept;

    // Handshake is suppressed during reset and clear so no element is half-taken.
    assign in_ready  = rst_n && !clear && (state == LOAD);
    assign accept    = in_valid && in_ready;
    assign neu_en    = (state == FIRE);
    assign res_valid = (state == DONE);
    assign busy      = !((state == LOAD) && (slot == '0));

    // Next-state logic
    always_comb begin
        state_d  = state;
        slot_d   = slot;
        en_cnt_d = en_cnt;
        if (clear) begin
            state_d  = LOAD;
            slot_d   = '0;
            en_cnt_d = '0;
        end else begin
            case (state)
                LOAD: begin
                    if (accept) begin
                        if (slot == LOG_N_INPUTS'(N_INPUTS - 1)) begin
                            slot_d   = '0;
                            en_cnt_d = '0;
                            state_d  = FIRE;
                        end else begin
                            slot_d = LOG_N_INPUTS'(slot + 1'b1);
                        end
                    end
                end
                FIRE: begin
                    if (en_cnt == EW'(LATENCY - 1)) begin
                        en_cnt_d = '0;
                        state_d  = CAPT;
                    end else begin
                        en_cnt_d = EW'(en_cnt + 1'b1);
                    end
                end
                CAPT: state_d = DONE;
                DONE: if (res_ready) state_d = LOAD;
                default: state_d = LOAD;
            endcase
        end
    end

    // State, counters and datapath registers
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state    <= LOAD;
            slot     <= '0;
            en_cnt   <= '0;
            w_packed <= '0;
            x_packed <= '0;
            res_data <= '0;
        end else begin
            state  <= state_d;
            slot   <= slot_d;
            en_cnt <= en_cnt_d;
            for (int k = 0; k < int'(N_INPUTS); k++) begin
                if (accept && (slot == LOG_N_INPUTS'(k))) begin
                    w_packed[k*N +: N] <= in_w;
                    x_packed[k*N +: N] <= in_x;
                end
            end
            if ((state == CAPT) && !clear) begin
                res_data <= neu_out;
            end
        end
    end

endmodule

// File: tb/tb_neuron_vec_loader.sv
// Randomized scoreboard bench for neuron_vec_loader with a small packed-neuron model.
module tb_neuron_vec_loader;

    localparam int unsigned N   = 8;
    localparam int unsigned NI  = 4;
    localparam int unsigned LOG = 2;
    localparam int unsigned LAT = 2;

    logic            clk = 1'b0;
    logic            rst_n = 1'b0;
    logic            clear = 1'b0;
    logic            in_valid = 1'b0;
    logic            in_ready;
    logic [N-1:0]    in_w = '0;
    logic [N-1:0]    in_x = '0;
    logic [N*NI-1:0] w_packed;
    logic [N*NI-1:0] x_packed;
    logic            neu_en;
    logic [N-1:0]    neu_out;
    logic            res_valid;
    logic            res_ready;
    logic [N-1:0]    res_data;
    logic            busy;

    int checks = 0;
    int failures = 0;
    int rr_mode = 1;
    logic [N-1:0] sb[$];
    logic [N-1:0] fw[$];
    logic [N-1:0] fx[$];
    logic [N-1:0] last_exp = '0;

    neuron_vec_loader #(.N(N), .N_INPUTS(NI), .LOG_N_INPUTS(LOG), .LATENCY(LAT)) dut (
        .clk(clk), .rst_n(rst_n), .clear(clear), .in_valid(in_valid), .in_ready(in_ready),
        .in_w(in_w), .in_x(in_x), .w_packed(w_packed), .x_packed(x_packed), .neu_en(neu_en),
        .neu_out(neu_out), .res_valid(res_valid), .res_ready(res_ready), .res_data(res_data),
        .busy(busy)
    );

    always #5 clk = ~clk;

    // Neuron stand-in: acc register then saturated-ReLU output register
    int acc_m = 0;
    logic [N-1:0] nout_m = '0;
    assign neu_out = nout_m;

    function automatic logic [N-1:0] relu_sat(input int v);
        if (v < 0) return '0;
        if (v > 127) return 8'd127;
        return N'(v);
    endfunction

    function automatic int dot_packed(input logic [N*NI-1:0] w, input logic [N*NI-1:0] x);
        int s = 0;
        for (int k = 0; k < int'(NI); k++) begin
            s += int'($signed(w[k*N +: N])) * int'($signed(x[k*N +: N]));
        end
        return s;
    endfunction

    always @(posedge clk) begin
        if (neu_en) begin
            acc_m  <= dot_packed(w_packed, x_packed);
            nout_m <= relu_sat(acc_m);
        end
    end

    // Reference: expected result from the list of accepted pairs
    function automatic logic [N-1:0] ref_result();
        int s = 0;
        for (int i = 0; i < fw.size(); i++) begin
            s += int'($signed(fw[i])) * int'($signed(fx[i]));
        end
        return relu_sat(s);
    endfunction

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=%0h expected=%0h", name, act, exp);
        end
    endtask

    task automatic note_accept(input logic [N-1:0] w, input logic [N-1:0] x);
        fw.push_back(w);
        fx.push_back(x);
        if (fw.size() == int'(NI)) begin
            last_exp = ref_result();
            sb.push_back(last_exp);
            fw.delete();
            fx.delete();
        end
    endtask

    // Offer one pair starting at posedge+1; returns at posedge+1 after the handshake.
    task automatic send(input logic [N-1:0] w, input logic [N-1:0] x);
        int t = 0;
        in_w = w;
        in_x = x;
        in_valid = 1'b1;
        forever begin
            @(negedge clk);
            if (in_ready) break;
            t++;
            if (t > 50) begin
                check("send_timeout", 1, 0);
                in_valid = 1'b0;
                return;
            end
            @(posedge clk); #1;
        end
        @(posedge clk); #1;
        in_valid = 1'b0;
        note_accept(w, x);
    endtask

    task automatic wait_valid(output int cyc);
        cyc = 0;
        while (cyc < 40) begin
            @(negedge clk);
            cyc++;
            if (res_valid) return;
        end
        check("wait_valid_timeout", 0, 1);
    endtask

    task automatic tick();
        @(posedge clk); #1;
    endtask

    // Result consumer back-pressure
    initial begin
        res_ready = 1'b1;
        forever begin
            @(posedge clk); #2;
            if (rr_mode == 2) res_ready = 1'($urandom_range(0, 1));
            else              res_ready = (rr_mode == 1);
        end
    end

    // Monitor: every completed result handshake is compared against the scoreboard
    always @(negedge clk) begin
        if (rst_n && res_valid && res_ready) begin
            if (sb.size() == 0) begin
                check("unexpected_result", 1, 0);
            end else begin
                check("res_data", res_data, sb.pop_front());
            end
        end
    end

    initial begin
        #400000;
        $display("FAIL watchdog actual=timeout expected=finish");
        $fatal(1, "watchdog");
    end

    initial begin
        int cyc;
        int en;
        logic [N-1:0] rw;
        logic [N-1:0] rx;

        // Reset
        rst_n = 1'b0;
        repeat (2) @(posedge clk);
        @(negedge clk);
        check("rst_in_ready", in_ready, 0);
        check("rst_res_valid", res_valid, 0);
        check("rst_neu_en", neu_en, 0);
        check("rst_w_packed", w_packed, 0);
        check("rst_x_packed", x_packed, 0);
        check("rst_res_data", res_data, 0);
        check("rst_busy", busy, 0);
        tick();
        rst_n = 1'b1;
        tick();

        // Basic frame, latency and enable length
        rr_mode = 1;
        send(8'd1, 8'd2); send(8'd2, 8'd2); send(8'd3, 8'd2); send(8'd4, 8'd2);
        en = 0;
        cyc = 0;
        while (cyc < 20) begin
            @(negedge clk);
            cyc++;
            if (neu_en) en++;
            if (res_valid) break;
        end
        check("latency", cyc, 4);
        check("neu_en_len", en, 2);
        check("res_data_20", res_data, 20);
        @(negedge clk);
        check("res_valid_pulse", res_valid, 0);
        check("in_ready_after", in_ready, 1);
        tick();

        // Negative clamp and packed layout
        repeat (4) send(8'hFF, 8'd5);
        wait_valid(cyc);
        check("w_packed_neg", w_packed, 32'hFFFFFFFF);
        check("x_packed_5", x_packed, 32'h05050505);
        check("res_data_clamp0", res_data, 0);
        tick();

        // Saturation
        repeat (4) send(8'd100, 8'd100);
        wait_valid(cyc);
        check("res_data_sat", res_data, 127);
        tick();

        // Result back-pressure
        rr_mode = 0;
        tick();
        for (int i = 0; i < int'(NI); i++) send(N'($urandom), N'($urandom));
        wait_valid(cyc);
        in_valid = 1'b1;
        in_w = 8'h11;
        in_x = 8'h22;
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            check("hold_valid", res_valid, 1);
            check("hold_data", res_data, last_exp);
            check("hold_in_ready", in_ready, 0);
        end
        tick();
        rr_mode = 1;
        @(negedge clk);
        check("accept_cycle_in_ready", in_ready, 0);
        check("accept_cycle_valid", res_valid, 1);
        tick();
        in_valid = 1'b0;

        // Gapped input
        for (int i = 0; i < int'(NI); i++) begin
            send(N'(i + 1), 8'd2);
            if (i < int'(NI) - 1) begin
                @(negedge clk);
                check("gap_neu_en", neu_en, 0);
                check("gap_busy", busy, 1);
                tick();
            end
        end
        wait_valid(cyc);
        check("gap_res", res_data, 20);
        tick();

        // Reset during FIRE
        for (int i = 0; i < int'(NI); i++) send(N'($urandom), N'($urandom));
        rst_n = 1'b0;
        @(posedge clk);
        @(negedge clk);
        sb.delete();
        check("rstfire_neu_en", neu_en, 0);
        check("rstfire_valid", res_valid, 0);
        check("rstfire_w", w_packed, 0);
        check("rstfire_x", x_packed, 0);
        check("rstfire_res", res_data, 0);
        check("rstfire_in_ready", in_ready, 0);
        tick();
        rst_n = 1'b1;
        @(negedge clk);
        check("post_rst_in_ready", in_ready, 1);
        check("post_rst_busy", busy, 0);
        tick();

        // Clear after two accepts
        send(8'd7, 8'd7); send(8'd7, 8'd7);
        clear = 1'b1;
        in_valid = 1'b1;
        @(negedge clk);
        check("clear_in_ready", in_ready, 0);
        check("clear_busy_before", busy, 1);
        tick();
        clear = 1'b0;
        in_valid = 1'b0;
        fw.delete();
        fx.delete();
        en = 0;
        for (int i = 0; i < 6; i++) begin
            @(negedge clk);
            if (res_valid || neu_en) en++;
        end
        check("clear_no_activity", en, 0);
        check("clear_busy_after", busy, 0);
        tick();
        send(8'd1, 8'd2); send(8'd2, 8'd2); send(8'd3, 8'd2); send(8'd4, 8'd2);
        wait_valid(cyc);
        check("clear_recover_res", res_data, 20);
        tick();

        // Random frames with random gaps and back-pressure
        rr_mode = 2;
        for (int f = 0; f < 12; f++) begin
            for (int i = 0; i < int'(NI); i++) begin
                repeat ($urandom_range(0, 2)) tick();
                rw = N'($urandom);
                rx = N'($urandom);
                if (f % 3 == 0) rx = N'($urandom_range(0, 15));
                send(rw, rx);
            end
        end
        rr_mode = 1;
        cyc = 0;
        while (sb.size() != 0 && cyc < 100) begin
            @(negedge clk);
            cyc++;
        end
        check("sb_drained", sb.size(), 0);
        repeat (2) tick();

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/neuron_vec_loader.md
Name: neuron_vec_loader

Overview:
- Upstream feeder for the packed-input neuron (N-bit weights/inputs, N_INPUTS lanes, saturated-ReLU output).
- Accepts one (weight, input) pair per handshake and assembles the packed W and X_N vectors.
- Drives the neuron enable for exactly the neuron's register depth, then captures the neuron output.
- Returns the captured result over a valid/ready result port; one result per N_INPUTS-element frame.

Parameters:
- N, 64, element width in bits (weights, inputs, result).
- N_INPUTS, 16, elements per frame; power of two, >= 2.
- LOG_N_INPUTS, 4, log2(N_INPUTS); sizes the slot counter.
- LATENCY, 2, number of neuron enable cycles needed for a frame to reach the neuron output (acc register, then Out register); >= 1.

Ports:
- clk, in, 1, clock; all logic on the rising edge.
- rst_n, in, 1, synchronous active-low reset.
- clear, in, 1, synchronous abort of the current frame; no result is produced.
- in_valid, in, 1, an element pair is offered.
- in_ready, out, 1, the loader accepts an element this cycle.
- in_w, in, N, signed weight element.
- in_x, in, N, signed input element.
- w_packed, out, N*N_INPUTS, to neuron W; slot k is bits [k*N +: N].
- x_packed, out, N*N_INPUTS, to neuron X_N; same slot layout.
- neu_en, out, 1, neuron enable.
- neu_out, in, N, neuron Out.
- res_valid, out, 1, result available.
- res_ready, in, 1, consumer accepts the result.
- res_data, out, N, captured neuron output.
- busy, out, 1, high in every state except LOAD with slot counter 0.

Behaviour:
- Reset (rst_n=0 at a clock edge): state=LOAD, slot=0, en_cnt=0, w_packed=0, x_packed=0, res_data=0, neu_en=0, res_valid=0, in_ready=0 during the reset cycle.
- States: LOAD, FIRE, CAPT, DONE.
- LOAD:
  - in_ready=1.
  - Accept when in_valid&&in_ready: write in_w to w_packed slot[slot] and in_x to x_packed slot[slot]; slot++.
  - Accepting with slot==N_INPUTS-1 sets slot=0, en_cnt=0, and moves to FIRE.
  - Gaps in in_valid are allowed; the counter holds.
- FIRE:
  - neu_en=1 for exactly LATENCY consecutive cycles; en_cnt counts 0..LATENCY-1; then move to CAPT.
  - in_ready=0.
  - The packed vectors do not change.
- CAPT:
  - One cycle; neu_en=0.
  - res_data <= neu_out; move to DONE.
  - neu_out is sampled in this cycle, i.e. exactly LATENCY cycles after the first neu_en.
- DONE:
  - res_valid=1; res_data stable.
  - When res_ready=1: move to LOAD.
  - res_valid stays high until accepted.
  - in_ready=0 throughout, including the accept cycle; the next element is accepted no earlier than the cycle after the result handshake.
- Latency:
  - From the final element accept to res_valid: LATENCY+2 cycles, i.e. 4 with the default.
  - Minimum frame period: N_INPUTS + LATENCY + 2 cycles.
- Packed vectors hold their last frame until overwritten slot by slot; stale slots are never fired because FIRE requires all N_INPUTS accepts.
- clear=1 (any state, rst_n=1):
  - Next state LOAD, slot=0, en_cnt=0, neu_en=0, res_valid=0.
  - The element offered in that cycle is not accepted (in_ready forced 0).
  - Packed vectors and res_data are not cleared.
- Precedence: rst_n over clear over normal operation.
- Reset or clear during FIRE: the neuron's internal registers may retain partial values. This is harmless because the next frame applies LATENCY fresh enables before capture.
- No arithmetic in this block; elements pass bit-exact. Signed interpretation matters only to the neuron.

Test Plan:
- Config N=8, N_INPUTS=4, LOG=2, LATENCY=2. Feed pairs (1,2),(2,2),(3,2),(4,2) back-to-back with res_ready=1 -> neu_en high 2 cycles, res_data=20, res_valid 4 cycles after the 4th accept, for 1 cycle.
- Feed four pairs (-1,5) -> res_data=0 (ReLU negative clamp); w_packed=0xFFFFFFFF, x_packed=0x05050505.
- Feed four pairs (100,100) -> res_data=127 (saturation).
- Hold res_ready=0 for 5 cycles after res_valid -> res_valid and res_data stable, in_ready=0; the next frame is accepted only after res_ready=1.
- in_valid toggling 1,0,1,0,... -> slot advances only on handshakes; FIRE entered only after the 4th accept; result as in the first scenario.
- rst_n=0 during FIRE -> next cycle all outputs are zero and state is LOAD. clear after 2 accepts -> no res_valid; a full new frame then gives the correct result.
